// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller between the MEM stage and a byte-wide
// synchronous RAM. Serves byte/half/word loads and stores (size-encoded 01/10/11),
// assembles read bytes little-endian into a zero-extended 32-bit word and issues a
// registered one-cycle completion pulse that releases the MEM-stage stall.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   mem_addr_i/mem_wdata_i    request byte address and store data
//   mem_read_req_i            00 none, 01 byte, 10 half, 11 word
//   mem_write_req_i           same encoding, wins over a simultaneous read
//   mem_rdata_o               assembled read data (held until next read accepted)
//   mem_data_enable_o         one-cycle completion pulse
//   ram_a_o/ram_dout_o/ram_wr_o  RAM address, write byte, write strobe
//   ram_din_i                 RAM read byte, valid one cycle after its address
//
// Optional build macro MEM_CTRL_IF_PORT_EN adds an instruction-fetch port
// (if_req_i, if_addr_i, if_data_o, if_data_enable_o); fetches are word reads that
// lose arbitration to data requests in IDLE.
//
// A port's request must be seen at 00 at least once after it was accepted before
// it can be accepted again, so a request still held through DONE and into the
// following IDLE cycle does not start a second access.
module mem_ctrl #(
    parameter int unsigned ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [1:0]        mem_read_req_i,
    input  logic [1:0]        mem_write_req_i,
    output logic [31:0]       mem_rdata_o,
    output logic              mem_data_enable_o,
    output logic [ADDR_W-1:0] ram_a_o,
    output logic [7:0]        ram_dout_o,
    input  logic [7:0]        ram_din_i,
    output logic              ram_wr_o
`ifdef MEM_CTRL_IF_PORT_EN
    ,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [31:0]       if_data_o,
    output logic              if_data_enable_o
`endif
);

    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_e;

    // Size field to byte count; 00 maps to 0 (no request).
    function automatic logic [CNT_W-1:0] size_of(input logic [1:0] enc);
        case (enc)
            2'b01:   size_of = CNT_W'(1);
            2'b10:   size_of = CNT_W'(2);
            2'b11:   size_of = CNT_W'(4);
            default: size_of = CNT_W'(0);
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  size_q, size_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              d_armed_q, d_armed_d;
    logic [CNT_W-1:0]  cnt_nx;
    logic [1:0]        byte_idx;
`ifdef MEM_CTRL_IF_PORT_EN
    logic              fetch_q, fetch_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              if_en_q, if_en_d;
    logic              f_armed_q, f_armed_d;
`endif

    assign cnt_nx   = cnt_q + CNT_W'(1);
    // In RD cycle k>=1 the RAM returns byte k-1.
    assign byte_idx = 2'(cnt_q - CNT_W'(1));

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        size_d     = size_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        en_d       = 1'b0;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;
        d_armed_d  = d_armed_q | ((mem_read_req_i == 2'b00) && (mem_write_req_i == 2'b00));
`ifdef MEM_CTRL_IF_PORT_EN
        fetch_d    = fetch_q;
        if_data_d  = if_data_q;
        if_en_d    = 1'b0;
        f_armed_d  = f_armed_q | ~if_req_i;
`endif
        case (state_q)
            ST_IDLE: begin
                if (d_armed_q && (mem_write_req_i != 2'b00)) begin
                    base_d     = mem_addr_i;
                    size_d     = size_of(mem_write_req_i);
                    wdata_d    = mem_wdata_i;
                    cnt_d      = '0;
                    ram_a_d    = mem_addr_i;
                    ram_dout_d = mem_wdata_i[7:0];
                    ram_wr_d   = 1'b1;
                    d_armed_d  = 1'b0;
`ifdef MEM_CTRL_IF_PORT_EN
                    fetch_d    = 1'b0;
`endif
                    state_d    = ST_WR;
                end else if (d_armed_q && (mem_read_req_i != 2'b00)) begin
                    base_d     = mem_addr_i;
                    size_d     = size_of(mem_read_req_i);
                    wdata_d    = mem_wdata_i;
                    cnt_d      = '0;
                    ram_a_d    = mem_addr_i;
                    rdata_d    = '0;
                    d_armed_d  = 1'b0;
`ifdef MEM_CTRL_IF_PORT_EN
                    fetch_d    = 1'b0;
`endif
                    state_d    = ST_RD;
                end
`ifdef MEM_CTRL_IF_PORT_EN
                else if (f_armed_q && if_req_i) begin
                    base_d     = if_addr_i;
                    size_d     = CNT_W'(4);
                    cnt_d      = '0;
                    ram_a_d    = if_addr_i;
                    if_data_d  = '0;
                    f_armed_d  = 1'b0;
                    fetch_d    = 1'b1;
                    state_d    = ST_RD;
                end
`endif
            end
            ST_RD: begin
                if (cnt_q != '0) begin
`ifdef MEM_CTRL_IF_PORT_EN
                    if (fetch_q) if_data_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
                    else
`endif
                    rdata_d[{byte_idx, 3'b000} +: 8] = ram_din_i;
                end
                if (cnt_q == size_q) begin
`ifdef MEM_CTRL_IF_PORT_EN
                    if (fetch_q) if_en_d = 1'b1;
                    else
`endif
                    en_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_nx;
                    // Address stops advancing after the last byte has been presented.
                    if (cnt_nx < size_q) ram_a_d = base_q + ADDR_W'(cnt_nx);
                end
            end
            ST_WR: begin
                if (cnt_nx < size_q) begin
                    cnt_d      = cnt_nx;
                    ram_a_d    = base_q + ADDR_W'(cnt_nx);
                    ram_dout_d = wdata_q[{cnt_nx[1:0], 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end else begin
                    en_d    = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            size_q     <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            en_q       <= 1'b0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            d_armed_q  <= 1'b1;
`ifdef MEM_CTRL_IF_PORT_EN
            fetch_q    <= 1'b0;
            if_data_q  <= '0;
            if_en_q    <= 1'b0;
            f_armed_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            size_q     <= size_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            en_q       <= en_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
            d_armed_q  <= d_armed_d;
`ifdef MEM_CTRL_IF_PORT_EN
            fetch_q    <= fetch_d;
            if_data_q  <= if_data_d;
            if_en_q    <= if_en_d;
            f_armed_q  <= f_armed_d;
`endif
        end
    end

    assign mem_rdata_o       = rdata_q;
    assign mem_data_enable_o = en_q;
    assign ram_a_o           = ram_a_q;
    assign ram_dout_o        = ram_dout_q;
    assign ram_wr_o          = ram_wr_q;
`ifdef MEM_CTRL_IF_PORT_EN
    assign if_data_o         = if_data_q;
    assign if_data_enable_o  = if_en_q;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte-wide synchronous RAM model, table of load/store
// vectors with expected read data and latency, scoreboard of expected mem_rdata_o
// values popped on every completion pulse, and hand-written multi-cycle sequences.
module tb_mem_ctrl;
    localparam int unsigned ADDR_W = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [1:0]        mem_rd;
    logic [1:0]        mem_wr;
    logic [31:0]       mem_rdata;
    logic              mem_en;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;
    logic              ram_wr;
`ifdef MEM_CTRL_IF_PORT_EN
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [31:0]       if_data;
    logic              if_en;
`endif

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_addr_i        (mem_addr),
        .mem_wdata_i       (mem_wdata),
        .mem_read_req_i    (mem_rd),
        .mem_write_req_i   (mem_wr),
        .mem_rdata_o       (mem_rdata),
        .mem_data_enable_o (mem_en),
        .ram_a_o           (ram_a),
        .ram_dout_o        (ram_dout),
        .ram_din_i         (ram_din),
        .ram_wr_o          (ram_wr)
`ifdef MEM_CTRL_IF_PORT_EN
        ,
        .if_req_i          (if_req),
        .if_addr_i         (if_addr),
        .if_data_o         (if_data),
        .if_data_enable_o  (if_en)
`endif
    );

    // Synchronous byte RAM: read data valid the cycle after the address.
    logic [7:0] ram [0:(1<<ADDR_W)-1];
    logic [7:0] ram_q;
    always @(posedge clk) begin
        if (ram_wr) ram[ram_a] <= ram_dout;
        ram_q <= ram[ram_a];
    end
    assign ram_din = ram_q;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int pulses   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Scoreboard: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (mem_en === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_enable: pulse at %0t with no outstanding request", $time);
            end else begin
                check("rdata", mem_rdata, exp_q.pop_front());
            end
        end
    end

    function automatic int tb_n(input logic [1:0] e);
        return (e == 2'b11) ? 4 : int'(e);
    endfunction

    // Drive one request in cycle 0, check the RAM-side sequence and the latency.
    task automatic run_req(input logic [1:0] rd, input logic [1:0] wr, input logic [ADDR_W-1:0] a,
                           input logic [31:0] wd, input logic [31:0] exp_rdata, input int lat,
                           input bit hold);
        int n;
        int got;
        bit is_wr;
        is_wr = (wr != 2'b00);
        n     = is_wr ? tb_n(wr) : tb_n(rd);
        got   = -1;
        exp_q.push_back(exp_rdata);
        @(posedge clk); #1;
        mem_rd = rd; mem_wr = wr; mem_addr = a; mem_wdata = wd;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 1 && c <= n) begin
                check("ram_a", 32'(ram_a), 32'(ADDR_W'(32'(a) + 32'(c - 1))));
                check("ram_wr", 32'(ram_wr), 32'(is_wr));
                if (is_wr) check("ram_dout", 32'(ram_dout), 32'(8'(wd >> (8 * (c - 1)))));
            end
            if (mem_en === 1'b1) begin
                got = c;
                break;
            end
        end
        check("latency", 32'(got), 32'(lat));
        if (hold) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        mem_rd = 2'b00; mem_wr = 2'b00;
    endtask

    typedef struct {
        logic [1:0]        rd;
        logic [1:0]        wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       exp_rdata;
        int                lat;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_pulses;
        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
        ram[17'h00100] = 8'h11; ram[17'h00101] = 8'h22;
        ram[17'h00102] = 8'h33; ram[17'h00103] = 8'h44;
        ram[17'h00202] = 8'h5A;
        ram[17'h1FFFF] = 8'hA5; ram[17'h00000] = 8'h3C;
        ram[17'h1FFFE] = 8'hE1; ram[17'h00001] = 8'h0F;

        //            rd     wr     addr        wdata         exp rdata     lat
        vecs[0]  = '{2'b11, 2'b00, 17'h00100, 32'h0,        32'h44332211, 6};
        vecs[1]  = '{2'b00, 2'b10, 17'h00200, 32'hDEADBEEF, 32'h44332211, 3};
        vecs[2]  = '{2'b01, 2'b00, 17'h1FFFF, 32'h0,        32'h000000A5, 3};
        vecs[3]  = '{2'b10, 2'b00, 17'h1FFFF, 32'h0,        32'h00003CA5, 4};
        vecs[4]  = '{2'b00, 2'b11, 17'h00300, 32'h12345678, 32'h00003CA5, 5};
        vecs[5]  = '{2'b11, 2'b00, 17'h00300, 32'h0,        32'h12345678, 6};
        vecs[6]  = '{2'b11, 2'b01, 17'h00400, 32'h000000C3, 32'h12345678, 2};
        vecs[7]  = '{2'b01, 2'b00, 17'h00400, 32'h0,        32'h000000C3, 3};
        vecs[8]  = '{2'b10, 2'b00, 17'h00201, 32'h0,        32'h00005ABE, 4};
        vecs[9]  = '{2'b00, 2'b10, 17'h1FFFF, 32'h00007766, 32'h00005ABE, 3};
        vecs[10] = '{2'b11, 2'b00, 17'h1FFFE, 32'h0,        32'h0F7766E1, 6};

        rst = 1'b1;
        mem_rd = 2'b00; mem_wr = 2'b00; mem_addr = '0; mem_wdata = '0;
`ifdef MEM_CTRL_IF_PORT_EN
        if_req = 1'b0; if_addr = '0;
`endif
        repeat (2) @(negedge clk);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_enable", 32'(mem_en), 32'h0);
        check("reset_ram_a", 32'(ram_a), 32'h0);
        check("reset_ram_dout", 32'(ram_dout), 32'h0);
        check("reset_ram_wr", 32'(ram_wr), 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++)
            run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                    vecs[i].exp_rdata, vecs[i].lat, 1'b0);

        check("ram_0x200", 32'(ram[17'h00200]), 32'hEF);
        check("ram_0x201", 32'(ram[17'h00201]), 32'hBE);
        check("ram_0x202", 32'(ram[17'h00202]), 32'h5A);
        check("ram_0x303", 32'(ram[17'h00303]), 32'h12);
        check("ram_0x1FFFF", 32'(ram[17'h1FFFF]), 32'h66);
        check("ram_0x00000", 32'(ram[17'h00000]), 32'h77);

        // No request on either port: nothing happens.
        base_pulses = pulses;
        repeat (10) @(negedge clk);
        check("idle_pulses", 32'(pulses - base_pulses), 32'h0);
        check("idle_ram_wr", 32'(ram_wr), 32'h0);

        // Request held through DONE and one more cycle: single access only.
        base_pulses = pulses;
        run_req(2'b11, 2'b00, 17'h00100, 32'h0, 32'h44332211, 6, 1'b1);
        repeat (8) @(negedge clk);
        check("hold_pulses", 32'(pulses - base_pulses), 32'h1);
        check("hold_ram_a", 32'(ram_a), 32'h00103);
        check("hold_rdata", mem_rdata, 32'h44332211);

        // Asynchronous reset in WR cycle 2 of a word store.
        base_pulses = pulses;
        @(posedge clk); #1;
        mem_wr = 2'b11; mem_addr = 17'h00500; mem_wdata = 32'hCAFEF00D;
        repeat (3) @(negedge clk);
        check("wr_before_rst", 32'(ram_wr), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("wr_async_drop", 32'(ram_wr), 32'h0);
        check("rdata_async_clr", mem_rdata, 32'h0);
        mem_wr = 2'b00; mem_addr = '0; mem_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_no_pulse", 32'(pulses - base_pulses), 32'h0);
        run_req(2'b11, 2'b00, 17'h00100, 32'h0, 32'h44332211, 6, 1'b0);

`ifdef MEM_CTRL_IF_PORT_EN
        // Fetch and data read together: data first, then fetch.
        begin
            int d_lat;
            int f_lat;
            d_lat = -1;
            f_lat = -1;
            exp_q.push_back(32'h44332211);
            @(posedge clk); #1;
            mem_rd = 2'b11; mem_addr = 17'h00100;
            if_req = 1'b1; if_addr = 17'h00300;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (mem_en === 1'b1) d_lat = c;
                if (if_en === 1'b1) begin
                    f_lat = c;
                    break;
                end
                @(posedge clk); #1;
                if (d_lat >= 0) mem_rd = 2'b00;
            end
            check("fetch_data_lat", 32'(d_lat), 32'd6);
            check("fetch_lat", 32'(f_lat), 32'd13);
            check("fetch_data", if_data, 32'h12345678);
            @(posedge clk); #1;
            if_req = 1'b0; mem_rd = 2'b00;
            repeat (3) @(negedge clk);
        end
`endif

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
